// File: rtl/nap_pkg.sv
// Shared types and constants for the nap machine front end: key FSM states,
// key line count and the one-hot helpers used by the key debouncer.
package nap_pkg;

  typedef enum logic [1:0] {
    KS_IDLE     = 2'd0,
    KS_DEBOUNCE = 2'd1,
    KS_HELD     = 2'd2,
    KS_RELEASE  = 2'd3
  } key_state_t;

  localparam logic [3:0] KEY_SHARP = 4'd10;
  localparam int         KEY_LINES = 11;

  // True when exactly one key line is asserted.
  function automatic logic is_onehot(input logic [KEY_LINES-1:0] v);
    return (v != '0) && ((v & (v - KEY_LINES'(1))) == '0);
  endfunction

  // Bit index of a one-hot key vector; bit 10 (#) maps to KEY_SHARP.
  function automatic logic [3:0] encode_key(input logic [KEY_LINES-1:0] v);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 0; i < KEY_LINES; i++) begin
      if (v[i]) begin
        code = 4'(i);
      end else begin
        code = code;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/sync2_bus.sv
// Two-flop synchroniser for a bus of independent asynchronous lines.
module sync2_bus #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Both stages clear on reset so nothing stale survives into the FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_debouncer.sv
// Keypad / # key / DIP conditioning: synchronise, debounce, and emit one
// registered single-cycle pulse per accepted press plus a clean DIP level.
module keypad_debouncer
  import nap_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] keypad_raw,
  input  logic       sharp_raw,
  input  logic       dip_raw,
  output logic [9:0] keypad,
  output logic       sharp,
  output logic [3:0] key_code,
  output logic       multi_key,
  output logic       dip_switch
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [11:0]          sync_s;
  logic [KEY_LINES-1:0] kv_s;
  logic                 dip_s;

  key_state_t           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [KEY_LINES-1:0] cap_q, cap_d;
  logic [9:0]           keypad_q, keypad_d;
  logic                 sharp_q, sharp_d;
  logic [3:0]           key_code_q, key_code_d;
  logic                 multi_q, multi_d;
  logic [CW-1:0]        dcnt_q, dcnt_d;
  logic                 dip_q, dip_d;

  sync2_bus #(.W(12)) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   ({dip_raw, sharp_raw, keypad_raw}),
    .q_o   (sync_s)
  );

  assign kv_s  = sync_s[10:0];
  assign dip_s = sync_s[11];

  // Key FSM next state; pulse outputs default low so they last one cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    keypad_d   = 10'd0;
    sharp_d    = 1'b0;
    key_code_d = key_code_q;
    multi_d    = 1'b0;
    case (state_q)
      KS_IDLE: begin
        if (is_onehot(kv_s)) begin
          cap_d   = kv_s;
          cnt_d   = '0;
          state_d = KS_DEBOUNCE;
        end else if (kv_s != '0) begin
          multi_d = 1'b1;
        end else begin
          state_d = KS_IDLE;
        end
      end
      KS_DEBOUNCE: begin
        if (kv_s != cap_q) begin
          state_d = KS_IDLE;
        end else if (cnt_q == LAST) begin
          state_d    = KS_HELD;
          keypad_d   = cap_q[9:0];
          sharp_d    = cap_q[10];
          key_code_d = encode_key(cap_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      KS_HELD: begin
        if (kv_s == '0) begin
          cnt_d   = '0;
          state_d = KS_RELEASE;
        end else begin
          state_d = KS_HELD;
        end
      end
      KS_RELEASE: begin
        if (kv_s != '0) begin
          state_d = KS_HELD;
        end else if (cnt_q == LAST) begin
          state_d = KS_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = KS_IDLE;
      end
    endcase
  end

  // DIP level: toggle only after a full run of contrary samples.
  always_comb begin
    dip_d  = dip_q;
    dcnt_d = '0;
    if (dip_s != dip_q) begin
      if (dcnt_q == LAST) begin
        dip_d  = ~dip_q;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + CW'(1);
      end
    end else begin
      dcnt_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= KS_IDLE;
      cnt_q      <= '0;
      cap_q      <= '0;
      keypad_q   <= 10'd0;
      sharp_q    <= 1'b0;
      key_code_q <= 4'd0;
      multi_q    <= 1'b0;
      dcnt_q     <= '0;
      dip_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      keypad_q   <= keypad_d;
      sharp_q    <= sharp_d;
      key_code_q <= key_code_d;
      multi_q    <= multi_d;
      dcnt_q     <= dcnt_d;
      dip_q      <= dip_d;
    end
  end

  assign keypad     = keypad_q;
  assign sharp      = sharp_q;
  assign key_code   = key_code_q;
  assign multi_key  = multi_q;
  assign dip_switch = dip_q;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Scoreboard bench for keypad_debouncer with DEBOUNCE_CYCLES=4.
module tb_keypad_debouncer;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] keypad_raw;
  logic       sharp_raw;
  logic       dip_raw;
  logic [9:0] keypad;
  logic       sharp;
  logic [3:0] key_code;
  logic       multi_key;
  logic       dip_switch;

  keypad_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .keypad_raw (keypad_raw),
    .sharp_raw  (sharp_raw),
    .dip_raw    (dip_raw),
    .keypad     (keypad),
    .sharp      (sharp),
    .key_code   (key_code),
    .multi_key  (multi_key),
    .dip_switch (dip_switch)
  );

  always #5 clock = ~clock;

  // cyc = index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [9:0] kp;
    logic       sh;
    logic [3:0] code;
  } exp_t;

  exp_t sbq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // A key driven at the negedge of cycle c pulses visibly at cycle c+7.
  task automatic expect_pulse(input int at, input logic [3:0] code);
    exp_t e;
    e.at   = at;
    e.code = code;
    e.sh   = (code == 4'd10);
    e.kp   = (code == 4'd10) ? 10'd0 : (10'd1 << code);
    sbq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: every visible pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (keypad != 10'd0 || sharp) begin
      if (sbq.size() == 0) begin
        check("unexpected_pulse", 32'({keypad, sharp}), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.at));
        check("pulse_keypad", 32'(keypad), 32'(e.kp));
        check("pulse_sharp", 32'(sharp), 32'(e.sh));
        check("pulse_code", 32'(key_code), 32'(e.code));
      end
    end
  end

  initial begin
    int c;
    reset      = 1'b1;
    keypad_raw = 10'd0;
    sharp_raw  = 1'b0;
    dip_raw    = 1'b0;
    tick(3);
    check("rst_keypad", 32'(keypad), 32'd0);
    check("rst_sharp", 32'(sharp), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_multi", 32'(multi_key), 32'd0);
    check("rst_dip", 32'(dip_switch), 32'd0);
    reset = 1'b0;
    tick(2);

    // Clean press of key 7.
    keypad_raw = 10'b0010000000;
    expect_pulse(cyc + 7, 4'd7);
    tick(10);
    check("s1_multi", 32'(multi_key), 32'd0);
    tick(10);
    keypad_raw = 10'd0;
    tick(12);
    check("s1_code_hold", 32'(key_code), 32'd7);

    // Bouncing # key: 1-0-1 then stable.
    sharp_raw = 1'b1;
    tick(1);
    sharp_raw = 1'b0;
    tick(1);
    sharp_raw = 1'b1;
    expect_pulse(cyc + 7, 4'd10);
    tick(10);
    sharp_raw = 1'b0;
    tick(12);
    check("s2_code_hold", 32'(key_code), 32'd10);

    // Keys 2 and 5 together, then 5 released.
    keypad_raw = 10'b0000100100;
    tick(5);
    check("s3_multi_a", 32'(multi_key), 32'd1);
    tick(3);
    check("s3_multi_b", 32'(multi_key), 32'd1);
    keypad_raw = 10'b0000000100;
    expect_pulse(cyc + 7, 4'd2);
    tick(4);
    check("s3_multi_drop", 32'(multi_key), 32'd0);
    tick(6);
    keypad_raw = 10'd0;
    tick(12);

    // Hold 3, add 4, drop 3, glitch release, drop 4: only one pulse.
    keypad_raw = 10'b0000001000;
    expect_pulse(cyc + 7, 4'd3);
    tick(8);
    keypad_raw = 10'b0000011000;
    tick(3);
    check("s4_multi_held", 32'(multi_key), 32'd0);
    keypad_raw = 10'b0000010000;
    tick(3);
    keypad_raw = 10'd0;
    tick(2);
    keypad_raw = 10'b0000010000;
    tick(6);
    keypad_raw = 10'd0;
    tick(12);
    check("s4_code_hold", 32'(key_code), 32'd3);

    // DIP glitch of 3 cycles, then a stable high.
    dip_raw = 1'b1;
    tick(3);
    dip_raw = 1'b0;
    tick(2);
    check("s5_dip_glitch_a", 32'(dip_switch), 32'd0);
    tick(4);
    check("s5_dip_glitch_b", 32'(dip_switch), 32'd0);
    dip_raw = 1'b1;
    c = cyc;
    tick(5);
    check("s5_dip_early", 32'(dip_switch), 32'd0);
    tick(1);
    check("s5_dip_toggle", 32'(dip_switch), 32'd1);
    check("s5_dip_edge", 32'(cyc), 32'(c + 6));

    // Reset while key 9 is in DEBOUNCE; key held through reset.
    keypad_raw = 10'b1000000000;
    tick(3);
    reset = 1'b1;
    tick(3);
    check("s6_rst_keypad", 32'(keypad), 32'd0);
    check("s6_rst_code", 32'(key_code), 32'd0);
    check("s6_rst_multi", 32'(multi_key), 32'd0);
    check("s6_rst_dip", 32'(dip_switch), 32'd0);
    reset = 1'b0;
    expect_pulse(cyc + 7, 4'd9);
    tick(6);
    check("s6_dip_relearn", 32'(dip_switch), 32'd1);
    tick(6);
    keypad_raw = 10'd0;
    tick(12);
    check("s6_code_hold", 32'(key_code), 32'd9);
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
